// File: rtl/tag_alloc_queue.sv
// tag_alloc_queue: free-bitmap allocator for per-warp inflight-instruction tags.
// Offers the lowest-indexed free tags on NumTagOut ports. It takes tags on a
// get/valid handshake and returns freed tags to the pool on NumTagIn ports.
module tag_alloc_queue #(
  parameter  int NumTags   = 16,
  parameter  int NumTagOut = 2,
  parameter  int NumTagIn  = 2,
  localparam int TagWidth  = (NumTags > 1) ? $clog2(NumTags) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumTagIn-1:0]                 free_i,
  input  logic [NumTagIn-1:0][TagWidth-1:0]   tag_i,
  input  logic [NumTagOut-1:0]                get_i,
  output logic [NumTagOut-1:0]                valid_o,
  output logic [NumTagOut-1:0][TagWidth-1:0]  tag_o
);

  localparam int CntWidth = $clog2(NumTags + 1);

  // Binary encoding of a one-hot pick; an all-zero pick encodes to 0.
  function automatic logic [TagWidth-1:0] onehot_to_bin(input logic [NumTags-1:0] oh);
    logic [TagWidth-1:0] enc;
    enc = {TagWidth{1'b0}};
    for (int t = 0; t < NumTags; t++) begin
      if (oh[t]) begin
        enc = enc | TagWidth'(t);
      end else begin
        enc = enc;
      end
    end
    return enc;
  endfunction

  logic [NumTags-1:0]                 free_r;
  logic [NumTags-1:0]                 free_d_s;
  logic [NumTags-1:0]                 taken_s;
  logic [NumTags-1:0]                 freed_s;
  logic [NumTags-1:0][CntWidth-1:0]   prefix_s;
  logic [NumTagOut-1:0][NumTags-1:0]  pick_s;
  logic [NumTagOut-1:0]               valid_s;
  logic [NumTagOut-1:0][TagWidth-1:0] tag_s;

  // Prefix count: prefix_s[t] is the number of free tags strictly below t.
  always_comb begin
    logic [CntWidth-1:0] run;
    run      = {CntWidth{1'b0}};
    prefix_s = '0;
    for (int t = 0; t < NumTags; t++) begin
      prefix_s[t] = run;
      run         = run + CntWidth'(free_r[t]);
    end
  end

  // Port i picks the free tag that has exactly i free tags below it.
  always_comb begin
    pick_s = '0;
    for (int i = 0; i < NumTagOut; i++) begin
      for (int t = 0; t < NumTags; t++) begin
        pick_s[i][t] = free_r[t] & (prefix_s[t] == CntWidth'(i));
      end
    end
  end

  // Encode picks into offered tags; an empty pick gives valid=0 and tag=0.
  always_comb begin
    valid_s = '0;
    tag_s   = '0;
    for (int i = 0; i < NumTagOut; i++) begin
      valid_s[i] = |pick_s[i];
      tag_s[i]   = onehot_to_bin(pick_s[i]);
    end
  end

  assign valid_o = valid_s;
  assign tag_o   = tag_s;

  // Mask of tags taken this cycle: only ports that complete the handshake count.
  always_comb begin
    taken_s = {NumTags{1'b0}};
    for (int i = 0; i < NumTagOut; i++) begin
      if (get_i[i] && valid_s[i]) begin
        taken_s = taken_s | pick_s[i];
      end else begin
        taken_s = taken_s;
      end
    end
  end

  // Mask of tags returned this cycle; duplicate frees of one tag merge naturally.
  always_comb begin
    freed_s = {NumTags{1'b0}};
    for (int i = 0; i < NumTagIn; i++) begin
      for (int t = 0; t < NumTags; t++) begin
        if (free_i[i] && (tag_i[i] == TagWidth'(t))) begin
          freed_s[t] = 1'b1;
        end else begin
          freed_s[t] = freed_s[t];
        end
      end
    end
  end

  // Next bitmap: clear taken tags, then set freed ones (set wins).
  always_comb begin
    free_d_s = (free_r & ~taken_s) | freed_s;
  end

  // Free bitmap register; reset makes every tag free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_r <= {NumTags{1'b1}};
    end else begin
      free_r <= free_d_s;
    end
  end

endmodule

// File: tb/tb_tag_alloc_queue.sv
// Bench for tag_alloc_queue: a set-based reference model and a per-cycle
// compare process, plus directed literal checks and a random soak.
module tb_tag_alloc_queue;

  localparam int NT = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [1:0]      free_i = 2'b00;
  logic [1:0][3:0] tag_i = '0;
  logic [1:0]      get_i = 2'b00;
  logic [1:0]      valid_o;
  logic [1:0][3:0] tag_o;

  int checks = 0;
  int errors = 0;
  int got_cnt = 0;
  int freed_cnt = 0;

  tag_alloc_queue #(.NumTags(16), .NumTagOut(2), .NumTagIn(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .free_i(free_i), .tag_i(tag_i),
    .get_i(get_i), .valid_o(valid_o), .tag_o(tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]      vld;
    logic [1:0][3:0] tag;
  } offer_t;

  typedef struct packed {
    logic [15:0] fr;
    logic [15:0] hd;
    logic [1:0]  ng;
    logic [1:0]  nf;
  } mstep_t;

  logic [15:0] free_m;   // set of free tags
  logic [15:0] held_m;   // set of tags the consumer holds
  mstep_t      model_s;

  // Offer = first two members of the ascending list of free tags.
  function automatic offer_t model_offer(input logic [15:0] fm);
    offer_t o;
    int q[$];
    o = '0;
    for (int t = 0; t < NT; t++) if (fm[t]) q.push_back(t);
    for (int i = 0; i < 2; i++) begin
      if (q.size() > i) begin
        o.vld[i] = 1'b1;
        o.tag[i] = 4'(q[i]);
      end
    end
    return o;
  endfunction

  // One clock of the pool: takes move tags to the consumer, frees move them back.
  function automatic mstep_t model_next(input logic [15:0] fm, input logic [15:0] hm,
                                        input logic [1:0] g, input logic [1:0] f,
                                        input logic [1:0][3:0] ti);
    mstep_t s;
    offer_t o;
    o = model_offer(fm);
    s.fr = fm; s.hd = hm; s.ng = 2'd0; s.nf = 2'd0;
    for (int i = 0; i < 2; i++) begin
      if (g[i] && o.vld[i]) begin
        s.fr[o.tag[i]] = 1'b0;
        s.hd[o.tag[i]] = 1'b1;
        s.ng = s.ng + 2'd1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (f[i]) begin
        if (s.hd[ti[i]]) s.nf = s.nf + 2'd1;
        s.hd[ti[i]] = 1'b0;
        s.fr[ti[i]] = 1'b1;
      end
    end
    return s;
  endfunction

  assign model_s = model_next(free_m, held_m, get_i, free_i, tag_i);

  // Reference model state update, reset asynchronously like the pool.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_m <= 16'hFFFF;
      held_m <= 16'h0000;
    end else begin
      free_m    <= model_s.fr;
      held_m    <= model_s.hd;
      got_cnt   <= got_cnt + int'(model_s.ng);
      freed_cnt <= freed_cnt + int'(model_s.nf);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Per-cycle compare of the offer against the model, plus soak invariants.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      offer_t e;
      e = model_offer(free_m);
      chk("valid_o", 32'(valid_o), 32'(e.vld));
      for (int i = 0; i < 2; i++) begin
        chk("tag_o", 32'(tag_o[i]), e.vld[i] ? 32'(e.tag[i]) : 32'd0);
        if (valid_o[i]) chk("offer_not_held", 32'(held_m[tag_o[i]]), 32'd0);
      end
      if (valid_o == 2'b11) chk("ports_distinct", 32'(tag_o[0] != tag_o[1]), 32'd1);
      if (valid_o[0]) chk("held_lt_pool", 32'($countones(held_m) < NT), 32'd1);
    end
  end

  task automatic step(input logic [1:0] g, input logic [1:0] f,
                      input logic [3:0] a, input logic [3:0] b);
    get_i = g; free_i = f; tag_i[0] = a; tag_i[1] = b;
    @(posedge clk_i); #1;
    get_i = 2'b00; free_i = 2'b00;
  endtask

  initial begin
    bit done;
    int q[$];
    logic [1:0]      rg, rf;
    logic [3:0]      ra, rb;

    // Test 1: reset release.
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("t1_valid", 32'(valid_o), 32'd3);
    chk("t1_tag0", 32'(tag_o[0]), 32'd0);
    chk("t1_tag1", 32'(tag_o[1]), 32'd1);

    // Test 2: take both.
    step(2'b11, 2'b00, 4'd0, 4'd0);
    chk("t2_valid", 32'(valid_o), 32'd3);
    chk("t2_tag0", 32'(tag_o[0]), 32'd2);
    chk("t2_tag1", 32'(tag_o[1]), 32'd3);

    // Asynchronous reset mid-cycle returns all tags at once.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd3);
    chk("arst_tag0", 32'(tag_o[0]), 32'd0);
    chk("arst_tag1", 32'(tag_o[1]), 32'd1);
    @(negedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Test 3: take only port 1.
    step(2'b10, 2'b00, 4'd0, 4'd0);
    chk("t3_tag0", 32'(tag_o[0]), 32'd0);
    chk("t3_tag1", 32'(tag_o[1]), 32'd2);

    // Test 4: drain the pool, then free tag 5.
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(2'b11, 2'b00, 4'd0, 4'd0);
      if (valid_o == 2'b00) done = 1'b1;
    end
    chk("t4_drained", 32'(done), 32'd1);
    chk("t4_empty", 32'(valid_o), 32'd0);
    step(2'b00, 2'b01, 4'd5, 4'd0);
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_tag0", 32'(tag_o[0]), 32'd5);
    chk("t4_tag1", 32'(tag_o[1]), 32'd0);

    // Test 5: empty again, free 9 and 3 together.
    step(2'b01, 2'b00, 4'd0, 4'd0);
    chk("t5_empty", 32'(valid_o), 32'd0);
    step(2'b00, 2'b11, 4'd9, 4'd3);
    chk("t5_valid", 32'(valid_o), 32'd3);
    chk("t5_tag0", 32'(tag_o[0]), 32'd3);
    chk("t5_tag1", 32'(tag_o[1]), 32'd9);

    // Test 6: random soak until 1000 tags have been returned.
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      q.delete();
      for (int t = 0; t < NT; t++) if (held_m[t]) q.push_back(t);
      rg = 2'($urandom_range(0, 3));
      rf = 2'b00; ra = 4'd0; rb = 4'd0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rf[0] = 1'b1; ra = 4'(q[$urandom_range(0, q.size() - 1)]);
      end
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        rf[1] = 1'b1; rb = 4'(q[$urandom_range(0, q.size() - 1)]);
      end
      step(rg, rf, ra, rb);
      if (freed_cnt >= 1000) done = 1'b1;
    end
    chk("soak_reached_1000", 32'(done), 32'd1);
    chk("got_ge_freed", 32'(got_cnt >= freed_cnt), 32'd1);

    @(posedge clk_i); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
